// File: rtl/shapool_dispatch.sv
// rtl/shapool_dispatch.sv - job slicer and result collector for a shapool array
//
// Purpose: splits a job's nonce-MSB range (start..end inclusive, wrapping at 255)
// into one-MSB slices, hands each slice to the lowest-indexed idle pool, and queues
// every success as {pool index, nonce} in a first-word-fall-through result FIFO.
//
// Ports:
//   i_clk, i_reset           clock, synchronous active-high reset
//   i_job_valid/o_job_ready  job offer handshake (ready only while idle)
//   i_job_msb_start/_end     inclusive nonce-MSB range of the job
//   i_abort                  cancel the running job (FIFO and overflow kept)
//   o_pool_reset             per-pool hold/restart, registered
//   o_pool_nonce_msb         slice MSB of pool i at [8i+7:8i]
//   i_pool_success/_nonce    per-pool success pulse with its 32-bit nonce
//   i_pool_done              per-pool slice-exhausted pulse
//   o_res_valid/i_res_ready  result FIFO pop handshake
//   o_res_nonce, o_res_pool  FIFO head
//   o_job_done               one-cycle pulse on normal completion
//   o_overflow               sticky result-drop flag, cleared on job accept

module shapool_dispatch #(
  parameter int N_POOLS         = 4,
  parameter int N_POOLS_LOG2    = 2,
  parameter int FIFO_DEPTH      = 4,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_job_valid,
  output logic                    o_job_ready,
  input  logic [7:0]              i_job_msb_start,
  input  logic [7:0]              i_job_msb_end,
  input  logic                    i_abort,
  output logic [N_POOLS-1:0]      o_pool_reset,
  output logic [8*N_POOLS-1:0]    o_pool_nonce_msb,
  input  logic [N_POOLS-1:0]      i_pool_success,
  input  logic [32*N_POOLS-1:0]   i_pool_nonce,
  input  logic [N_POOLS-1:0]      i_pool_done,
  output logic                    o_res_valid,
  input  logic                    i_res_ready,
  output logic [31:0]             o_res_nonce,
  output logic [N_POOLS_LOG2-1:0] o_res_pool,
  output logic                    o_job_done,
  output logic                    o_overflow
);

  typedef enum logic [0:0] {S_IDLE, S_RUN} state_t;

  localparam logic [FIFO_DEPTH_LOG2:0] L_FULL = (FIFO_DEPTH_LOG2+1)'(FIFO_DEPTH);

  state_t r_state, w_state_next;

  logic [N_POOLS-1:0]         r_active, r_pending, r_pool_reset;
  logic [8*N_POOLS-1:0]       r_pool_msb;
  logic [31:0]                r_pend_nonce [N_POOLS];
  logic [7:0]                 r_next_msb;
  logic [8:0]                 r_remaining;
  logic                       r_job_done, r_overflow;

  logic [31:0]                r_fifo_nonce [FIFO_DEPTH];
  logic [N_POOLS_LOG2-1:0]    r_fifo_pool  [FIFO_DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr;
  logic [FIFO_DEPTH_LOG2:0]   r_count;

  logic                    w_accept, w_assign, w_complete;
  logic                    w_any_idle, w_any_pend, w_push, w_pop, w_drop;
  logic [N_POOLS_LOG2-1:0] w_idle_idx, w_drain_idx;
  logic [N_POOLS-1:0]      w_assign_oh, w_drain_oh, w_capture;
  logic [N_POOLS-1:0]      w_active_next, w_pending_next;

  // Lowest idle pool and lowest pending pool; the descending loop lets the
  // lowest index win.
  always_comb begin
    w_any_idle  = 1'b0;
    w_idle_idx  = '0;
    w_any_pend  = 1'b0;
    w_drain_idx = '0;
    for (int i = N_POOLS-1; i >= 0; i--) begin
      if (!r_active[i]) begin
        w_any_idle = 1'b1;
        w_idle_idx = N_POOLS_LOG2'(i);
      end
      if (r_pending[i]) begin
        w_any_pend  = 1'b1;
        w_drain_idx = N_POOLS_LOG2'(i);
      end
    end
  end

  // Abort overrides every dispatcher action; only host pops still happen.
  assign w_accept    = (r_state == S_IDLE) && i_job_valid && !i_abort;
  assign w_assign    = (r_state == S_RUN) && !i_abort && (r_remaining != 9'd0) && w_any_idle;
  assign w_assign_oh = w_assign ? (N_POOLS'(1) << w_idle_idx) : '0;
  assign w_complete  = (r_state == S_RUN) && (r_remaining == 9'd0) &&
                       (r_active == '0) && (r_pending == '0);

  assign w_pop       = i_res_ready && (r_count != '0);
  assign w_push      = !i_abort && w_any_pend && ((r_count != L_FULL) || w_pop);
  assign w_drain_oh  = w_push ? (N_POOLS'(1) << w_drain_idx) : '0;

  // A success is kept even if the same pool reports done in that cycle,
  // because capture looks at the current active bit.
  assign w_capture   = i_abort ? '0 : (i_pool_success & r_active & ~r_pending);
  assign w_drop      = !i_abort && ((i_pool_success & r_active & r_pending) != '0);

  assign w_active_next  = i_abort ? '0 : ((r_active & ~(i_pool_done & r_active)) | w_assign_oh);
  assign w_pending_next = i_abort ? '0 : ((r_pending & ~w_drain_oh) | w_capture);

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    o_job_ready  = (r_state == S_IDLE);
    case (r_state)
      S_IDLE:  if (w_accept) w_state_next = S_RUN;
      S_RUN:   if (i_abort || w_complete) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_active     <= '0;
      r_pending    <= '0;
      r_pool_reset <= '1;
      r_pool_msb   <= '0;
      r_next_msb   <= '0;
      r_remaining  <= '0;
      r_job_done   <= 1'b0;
      r_overflow   <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
    end else begin
      r_active   <= w_active_next;
      r_pending  <= w_pending_next;
      // New assignee sees one cycle of reset together with its new MSB.
      r_pool_reset <= ~w_active_next | w_assign_oh;
      r_job_done <= w_complete && !i_abort;

      if (i_abort) begin
        r_remaining <= '0;
      end else if (w_accept) begin
        r_next_msb  <= i_job_msb_start;
        r_remaining <= {1'b0, i_job_msb_end - i_job_msb_start} + 9'd1;
      end else if (w_assign) begin
        r_pool_msb[8*w_idle_idx +: 8] <= r_next_msb;
        r_next_msb  <= r_next_msb + 8'd1;
        r_remaining <= r_remaining - 9'd1;
      end

      if (w_accept)    r_overflow <= 1'b0;
      else if (w_drop) r_overflow <= 1'b1;

      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    for (int i = 0; i < N_POOLS; i++) begin
      if (w_capture[i]) r_pend_nonce[i] <= i_pool_nonce[32*i +: 32];
    end
    if (w_push) begin
      r_fifo_nonce[r_wr_ptr] <= r_pend_nonce[w_drain_idx];
      r_fifo_pool[r_wr_ptr]  <= w_drain_idx;
    end
  end

  assign o_pool_reset     = r_pool_reset;
  assign o_pool_nonce_msb = r_pool_msb;
  assign o_res_valid      = (r_count != '0);
  assign o_res_nonce      = r_fifo_nonce[r_rd_ptr];
  assign o_res_pool       = r_fifo_pool[r_rd_ptr];
  assign o_job_done       = r_job_done;
  assign o_overflow       = r_overflow;

endmodule

// File: tb/tb_shapool_dispatch.sv
// tb/tb_shapool_dispatch.sv - scoreboard bench for shapool_dispatch
module tb_shapool_dispatch;
  localparam int NP = 4;

  logic          clk = 1'b0;
  logic          reset, job_valid, abort, res_ready;
  logic [7:0]    msb_start, msb_end;
  logic [NP-1:0] pool_success, pool_done;
  logic [127:0]  pool_nonce;
  logic          job_ready, res_valid, job_done, overflow;
  logic [NP-1:0] pool_reset;
  logic [31:0]   pool_msb;
  logic [31:0]   res_nonce;
  logic [1:0]    res_pool;

  always #5 clk = ~clk;

  shapool_dispatch #(.N_POOLS(4), .N_POOLS_LOG2(2), .FIFO_DEPTH(4), .FIFO_DEPTH_LOG2(2)) dut (
    .i_clk(clk), .i_reset(reset), .i_job_valid(job_valid), .o_job_ready(job_ready),
    .i_job_msb_start(msb_start), .i_job_msb_end(msb_end), .i_abort(abort),
    .o_pool_reset(pool_reset), .o_pool_nonce_msb(pool_msb),
    .i_pool_success(pool_success), .i_pool_nonce(pool_nonce), .i_pool_done(pool_done),
    .o_res_valid(res_valid), .i_res_ready(res_ready), .o_res_nonce(res_nonce),
    .o_res_pool(res_pool), .o_job_done(job_done), .o_overflow(overflow)
  );

  typedef struct packed {logic [1:0] pool; logic [31:0] nonce;} res_t;

  int          tests = 0;
  int          fails = 0;
  int          done_seen = 0;
  res_t        exp_res[$];
  logic [9:0]  exp_asg[$];
  res_t        mon_res;
  logic [9:0]  mon_asg;
  logic [NP-1:0] prev_rst = '1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops result and assignment expectations as the DUT presents them.
  always @(negedge clk) begin
    if (res_valid && res_ready) begin
      if (exp_res.size() == 0) begin
        tests++; fails++;
        $display("FAIL res_unexpected: got pool %0d nonce 0x%08h, expected none", res_pool, res_nonce);
      end else begin
        mon_res = exp_res.pop_front();
        check("res_pool", res_pool, mon_res.pool);
        check("res_nonce", res_nonce, mon_res.nonce);
      end
    end
    if (job_done) done_seen++;
    for (int i = 0; i < NP; i++) begin
      if (prev_rst[i] && !pool_reset[i]) begin
        if (exp_asg.size() == 0) begin
          tests++; fails++;
          $display("FAIL asg_unexpected: got pool %0d msb 0x%02h, expected none", i, pool_msb[8*i +: 8]);
        end else begin
          mon_asg = exp_asg.pop_front();
          check("asg_pool", 64'(i), mon_asg[9:8]);
          check("asg_msb", pool_msb[8*i +: 8], mon_asg[7:0]);
        end
      end
    end
    prev_rst = pool_reset;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_asg(input int p, input int m);
    exp_asg.push_back({2'(p), 8'(m)});
  endtask

  task automatic push_res(input int p, input logic [31:0] n);
    exp_res.push_back({2'(p), n});
  endtask

  task automatic start_job(input logic [7:0] s, input logic [7:0] e);
    msb_start = s; msb_end = e; job_valid = 1'b1;
    tick();
    job_valid = 1'b0;
    check("job_accepted", job_ready, 1'b0);
  endtask

  task automatic pulse_done(input logic [NP-1:0] m);
    pool_done = m;
    tick();
    pool_done = '0;
  endtask

  task automatic wait_job_done(input string name, input int bound);
    int start_cnt;
    int k;
    start_cnt = done_seen;
    k = 0;
    while (done_seen == start_cnt && k < bound) begin
      tick();
      k++;
    end
    check(name, 64'(done_seen != start_cnt), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, expected $finish");
    $fatal(1);
  end

  initial begin
    int d0;
    reset = 1'b1; job_valid = 1'b0; abort = 1'b0; res_ready = 1'b0;
    msb_start = '0; msb_end = '0; pool_success = '0; pool_done = '0; pool_nonce = '0;
    tick(3);
    reset = 1'b0;
    tick();
    check("rst_job_ready", job_ready, 1'b1);
    check("rst_pool_reset", pool_reset, 4'hF);
    check("rst_pool_msb", pool_msb, 32'h0);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_job_done", job_done, 1'b0);

    // 1: 0x10..0x13 across four pools.
    push_asg(0, 8'h10); push_asg(1, 8'h11); push_asg(2, 8'h12); push_asg(3, 8'h13);
    start_job(8'h10, 8'h13);
    tick(8);
    check("t1_all_running", pool_reset, 4'h0);
    pulse_done(4'hF);
    wait_job_done("t1_job_done", 10);
    check("t1_job_ready", job_ready, 1'b1);
    check("t1_asg_left", exp_asg.size(), 0);

    // 2: wrapping job 0xFE..0x03 with reassignment after done.
    push_asg(0, 8'hFE); push_asg(1, 8'hFF); push_asg(2, 8'h00); push_asg(3, 8'h01);
    push_asg(2, 8'h02); push_asg(0, 8'h03);
    start_job(8'hFE, 8'h03);
    tick(8);
    pulse_done(4'b0100);
    tick(4);
    pulse_done(4'b0001);
    tick(4);
    check("t2_all_running", pool_reset, 4'h0);
    pulse_done(4'hF);
    wait_job_done("t2_job_done", 10);
    tick(3);
    check("t2_asg_left", exp_asg.size(), 0);
    check("t2_done_count", done_seen, 2);

    // 3: pools 1 and 3 succeed together; result latency two cycles.
    res_ready = 1'b1;
    push_asg(0, 8'h40); push_asg(1, 8'h41); push_asg(2, 8'h42); push_asg(3, 8'h43);
    start_job(8'h40, 8'h43);
    tick(8);
    push_res(1, 32'h0000_1234); push_res(3, 32'h0300_0042);
    pool_nonce[63:32] = 32'h0000_1234;
    pool_nonce[127:96] = 32'h0300_0042;
    pool_success = 4'b1010;
    tick();
    pool_success = '0;
    check("t3_latency_c1", res_valid, 1'b0);
    tick();
    check("t3_latency_c2", res_valid, 1'b1);
    tick(4);
    check("t3_res_left", exp_res.size(), 0);
    check("t3_overflow", overflow, 1'b0);
    pulse_done(4'hF);
    wait_job_done("t3_job_done", 10);

    // 4: FIFO fills, one pending, next dropped; then success+done in one cycle.
    res_ready = 1'b0;
    push_asg(0, 8'h50);
    start_job(8'h50, 8'h50);
    tick(4);
    for (int k = 1; k <= 6; k++) begin
      pool_nonce[31:0] = 32'hA000_0000 + 32'(k);
      if (k <= 5) push_res(0, 32'hA000_0000 + 32'(k));
      pool_success = 4'b0001;
      tick();
      pool_success = '0;
      tick();
    end
    check("t4_overflow_set", overflow, 1'b1);
    check("t4_res_valid", res_valid, 1'b1);
    res_ready = 1'b1;
    tick(8);
    check("t4_res_drained", exp_res.size(), 0);
    pool_nonce[31:0] = 32'hBEEF_0007;
    push_res(0, 32'hBEEF_0007);
    pool_success = 4'b0001; pool_done = 4'b0001;
    tick();
    pool_success = '0; pool_done = '0;
    wait_job_done("t4_job_done", 10);
    tick(3);
    check("t4_res_left", exp_res.size(), 0);
    check("t4_overflow_sticky", overflow, 1'b1);

    // 5: abort three cycles into 0x00..0xFF, then a single-slice job.
    push_asg(0, 8'h00);
    start_job(8'h00, 8'hFF);
    check("t5_overflow_cleared", overflow, 1'b0);
    tick(2);
    d0 = done_seen;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5_abort_pool_reset", pool_reset, 4'hF);
    check("t5_abort_job_ready", job_ready, 1'b1);
    tick(3);
    check("t5_no_job_done", done_seen, d0);
    push_asg(0, 8'h20);
    start_job(8'h20, 8'h20);
    tick(4);
    check("t5_single_msb", pool_msb[7:0], 8'h20);
    check("t5_single_reset", pool_reset, 4'b1110);
    pulse_done(4'b0001);
    wait_job_done("t5_job_done", 10);
    check("t5_asg_left", exp_asg.size(), 0);

    // 6: reset mid-job with FIFO non-empty and overflow set.
    res_ready = 1'b0;
    push_asg(0, 8'h30); push_asg(1, 8'h31);
    start_job(8'h30, 8'h31);
    tick(4);
    pool_nonce[31:0] = 32'h0000_0066;
    pool_success = 4'b0001;
    tick(2);
    pool_success = '0;
    tick(3);
    check("t6_res_valid_before", res_valid, 1'b1);
    check("t6_overflow_before", overflow, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_res_valid", res_valid, 1'b0);
    check("t6_pool_reset", pool_reset, 4'hF);
    check("t6_overflow", overflow, 1'b0);
    check("t6_job_ready", job_ready, 1'b1);
    tick(2);
    check("t6_asg_left", exp_asg.size(), 0);
    check("t6_res_left", exp_res.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
